// File: rtl/lib_event_pkg.sv
// lib_event_pkg: encoder state, default widths and event-word sizing.
// The timestamp field is present only when EVT_TIMESTAMP_EN is defined.
package lib_event_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} enc_state_e;
  localparam int DEF_ROW_ADD    = 3;
  localparam int DEF_COL_ADD    = 3;
  localparam int DEF_TS_WIDTH   = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_OVF_WIDTH  = 8;
`ifdef EVT_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  function automatic int evt_width(bit ts_en, int ts_w, int row, int col);
    return (ts_en ? ts_w : 0) + 1 + row + col;
  endfunction
endpackage

// File: rtl/evt_fifo.sv
// evt_fifo: synchronous FIFO with occupancy count; pop has priority so a push at full is accepted alongside it.
module evt_fifo #(
  parameter int W = 7,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr] <= din_i;
  assign count_o = r_count;
  assign empty_o = r_count == '0;
  assign full_o  = r_count == (AW+1)'(DEPTH);
  // Memory is not reset, so mask the head while empty to keep the output at zero.
  assign dout_o  = empty_o ? '0 : r_mem[r_rd];
endmodule

// File: rtl/pixel_event_encoder.sv
// pixel_event_encoder: turns arbiter grants into address-event words on a valid/ready stream.
// Defining EVT_TIMESTAMP_EN prepends a free-running timestamp to every word.
module pixel_event_encoder
  import lib_event_pkg::*;
#(
  parameter int ROW_ADD    = DEF_ROW_ADD,
  parameter int COL_ADD    = DEF_COL_ADD,
  parameter int TS_WIDTH   = DEF_TS_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int OVF_WIDTH  = DEF_OVF_WIDTH,
  localparam int DW = evt_width(TS_EN, TS_WIDTH, ROW_ADD, COL_ADD),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 active_i,
  input  logic [ROW_ADD-1:0]   x_add_i,
  input  logic [COL_ADD-1:0]   y_add_i,
  input  logic                 polarity_i,
  input  logic                 evt_ready_i,
  output logic                 evt_valid_o,
  output logic [DW-1:0]        evt_data_o,
  output logic                 stall_o,
  output logic                 fifo_empty_o,
  output logic [OVF_WIDTH-1:0] ovf_cnt_o,
  output logic                 busy_o
);
  enc_state_e                  r_state, w_next;
  logic                        r_active_q, r_stall;
  logic [ROW_ADD+COL_ADD-1:0]  r_last_addr, w_addr;
  logic [OVF_WIDTH-1:0]        r_ovf;
  logic                        w_strobe, w_pop, w_drop, w_full, w_empty;
  logic [CW-1:0]               w_count;
  logic [DW-1:0]               w_word;
  assign w_addr   = {x_add_i, y_add_i};
  // A grant held on the same pixel produces a single event.
  assign w_strobe = (r_state == RUN) & active_i & (~r_active_q | (w_addr != r_last_addr));
  assign w_pop    = ~w_empty & evt_ready_i;
  assign w_drop   = w_strobe & w_full & ~w_pop;
  always_comb w_next = enable_i ? RUN : (r_state == IDLE || w_empty) ? IDLE : DRAIN;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_state     <= IDLE;
      r_active_q  <= 1'b0;
      r_last_addr <= '0;
      r_ovf       <= '0;
      r_stall     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_active_q  <= active_i;
      r_last_addr <= w_addr;
      r_stall     <= w_count >= CW'(FIFO_DEPTH - 1);
      if (w_drop && r_ovf != '1) r_ovf <= r_ovf + 1'b1;
    end
`ifdef EVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_ts <= '0;
    else if (r_state == IDLE) begin
      if (enable_i) r_ts <= '0;
    end else r_ts <= r_ts + 1'b1;
  assign w_word = {r_ts, polarity_i, w_addr};
`else
  assign w_word = {polarity_i, w_addr};
`endif
  evt_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_strobe),
    .pop_i   (w_pop),
    .din_i   (w_word),
    .dout_o  (evt_data_o),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );
  assign evt_valid_o  = ~w_empty;
  assign fifo_empty_o = w_empty;
  assign stall_o      = r_stall;
  assign ovf_cnt_o    = r_ovf;
  assign busy_o       = r_state != IDLE;
endmodule

// File: tb/tb_pixel_event_encoder.sv
// tb_pixel_event_encoder: directed and random grants checked against a queue-based event model.
module tb_pixel_event_encoder;
  localparam int D = 8;
`ifdef EVT_TIMESTAMP_EN
  localparam int TW = 16;
`else
  localparam int TW = 0;
`endif
  localparam int DW = TW + 7;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, act = 1'b0, pol = 1'b0, rdy = 1'b0;
  logic [2:0] x = '0, y = '0;
  logic valid, stall, empty, busy;
  logic [DW-1:0] data;
  logic [7:0] ovf;
  logic [DW-1:0] q[$];
  int m_ovf, m_ts;
  bit m_run, m_drain, m_aq, m_stall;
  logic [5:0] m_last;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  pixel_event_encoder dut (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .active_i(act),
    .x_add_i(x), .y_add_i(y), .polarity_i(pol), .evt_ready_i(rdy),
    .evt_valid_o(valid), .evt_data_o(data), .stall_o(stall),
    .fifo_empty_o(empty), .ovf_cnt_o(ovf), .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic [DW-1:0] head;
    head = q.size() != 0 ? q[0] : '0;
    chk("valid", valid, q.size() != 0);
    chk("empty", empty, q.size() == 0);
    chk("data", data, head);
    chk("stall", stall, m_stall);
    chk("ovf", ovf, m_ovf);
    chk("busy", busy, m_run || m_drain);
  endtask
  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_ts = 0; m_run = 0; m_drain = 0; m_aq = 0; m_stall = 0; m_last = '0;
  endtask
  task automatic step();
    bit was_empty, pop, strobe;
    logic [DW-1:0] w;
    was_empty = q.size() == 0;
    pop = !was_empty && rdy;
    strobe = m_run && act && (!m_aq || {x, y} != m_last);
`ifdef EVT_TIMESTAMP_EN
    w = {m_ts[TW-1:0], pol, x, y};
`else
    w = {pol, x, y};
`endif
    m_stall = q.size() >= D - 1;
    if (pop) void'(q.pop_front());
    if (strobe) begin
      if (q.size() < D) q.push_back(w);
      else if (m_ovf < 255) m_ovf++;
    end
    if (!m_run && !m_drain) begin
      if (en) m_ts = 0;
    end else m_ts++;
    if (en) begin
      m_run = 1; m_drain = 0;
    end else if (m_run || m_drain) begin
      m_run = 0; m_drain = !was_empty;
    end
    m_last = {x, y};
    m_aq = act;
    @(posedge clk); #1;
    check_all();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst = 1'b0;
  endtask
  initial begin
    logic [DW-1:0] wa;
    logic [15:0] dts;
    model_reset();
    #2;
    check_all();
    do_reset();
    // single event from a held grant
    en = 1; step();
    act = 1; x = 3; y = 5; pol = 1; step();
    chk("t1_latency", valid, 1);
    chk("t1_word", data[6:0], 7'b1011101);
    repeat (9) step();
    chk("t1_held", data[6:0], 7'b1011101);
    rdy = 1; step();
    chk("t1_one_word", valid, 0);
    // moving grant, no duplicates
    rdy = 0; y = 6; repeat (3) step();
    x = 0; y = 0; repeat (3) step();
    chk("t2_first", data[5:0], 6'h1E);
    rdy = 1; step();
    chk("t2_second", data[5:0], 6'h00);
    step();
    chk("t2_done", valid, 0);
    // overflow with stalled consumer
    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      x = i[2:0]; y = ~i[2:0]; step();
    end
    chk("t3_ovf", ovf, 2);
    chk("t3_stall", stall, 1);
    // push at full with simultaneous pop
    x = 5; y = 5; rdy = 1; step();
    chk("t4_ovf", ovf, 2);
    chk("t4_valid", valid, 1);
    act = 0; repeat (9) step();
    chk("t4_empty", empty, 1);
    // drain on disable
    rdy = 0; act = 1;
    for (int i = 0; i < 4; i++) begin
      x = i[2:0]; y = 1; step();
    end
    en = 0; step();
    chk("t5_busy", busy, 1);
    rdy = 1;
    for (int i = 0; i < 6; i++) begin
      x = 3'($urandom); y = 3'($urandom); step();
    end
    chk("t5_idle", busy, 0);
    chk("t5_empty", empty, 1);
    // timestamp spacing, then asynchronous reset mid-stream
    do_reset();
    act = 0; rdy = 0; en = 1; step();
    repeat (4) step();
    act = 1; x = 1; y = 2; step();
    act = 0; repeat (14) step();
    act = 1; x = 2; step();
    act = 0;
    wa = data;
    rdy = 1; step();
    chk("t6_second_addr", data[5:0], 6'h12);
`ifdef EVT_TIMESTAMP_EN
    dts = data[DW-1:7] - wa[DW-1:7];
    chk("t6_ts_diff", dts, 16'd15);
`else
    dts = 16'(wa[5:0]);
    chk("t6_first_addr", dts, 16'h0A);
`endif
    rdy = 0; act = 1; x = 3; y = 3; step();
    x = 4; step();
    chk("t6_queued", valid, 1);
    rst = 1; #1;
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_empty", empty, 1);
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst = 0;
    // overflow counter saturation
    act = 0; en = 1; step();
    act = 1;
    for (int i = 0; i < 300; i++) begin
      x = i[2:0]; y = i[5:3]; step();
    end
    chk("ovf_sat", ovf, 8'hFF);
    do_reset();
    // random traffic
    for (int i = 0; i < 500; i++) begin
      en  = $urandom_range(0, 15) != 0;
      act = $urandom_range(0, 3) != 0;
      x   = 3'($urandom_range(0, 3));
      y   = 3'($urandom_range(0, 1));
      pol = 1'($urandom);
      rdy = $urandom_range(0, 2) != 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
